multi_input_debouncer: RTL and testbench

MULTI_INPUT_DEBOUNCER -- requirements
Module: multi_input_debouncer

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/input_synchronizer.sv | 27 ++
 rtl/multi_input_debouncer.sv | 117 +++++++++++
 tb/tb_multi_input_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel switch debouncer.
// Latency: n/a (definitions only).
// Backpressure: none; constants and helpers only.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } t_db_state;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    // The accepted level is high while the channel sits in, or is leaving, the high region.
    function automatic logic db_level(input t_db_state st);
        return (st == ST_HIGH) || (st == ST_WAIT_LOW);
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-bit flip-flop chain bringing asynchronous levels into the clk domain.
// Latency: STAGES clk edges from input to o_dout.
// Backpressure: none; free-running shift every cycle.
module input_synchronizer #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the raw levels through the chain; stage 0 is the metastability catcher.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_din};
        end
    end

    assign o_dout = r_sync[STAGES-1];

endmodule

// File: rtl/multi_input_debouncer.sv
// Independent per-channel debouncers with synchronizer, qualify counter and edge pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges from raw change to x_db change.
// Backpressure: none; every channel is evaluated every cycle.
module multi_input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] x_raw,
    output logic [N_INPUTS-1:0] x_db,
    output logic [N_INPUTS-1:0] x_rise,
    output logic [N_INPUTS-1:0] x_fall
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_INPUTS-1:0] w_sync;

    input_synchronizer #(
        .WIDTH  (N_INPUTS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (x_raw),
        .o_dout (w_sync)
    );

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
        t_db_state        r_state;
        t_db_state        w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_db_nxt;
        logic             r_db;
        logic             r_rise;
        logic             r_fall;

        // Advance the FSM state and qualify counter.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_LOW;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Next state: a level change must hold for DEBOUNCE_CYCLES samples; any bounce aborts.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_LOW: begin
                    if (w_sync[g]) begin
                        w_state_nxt = ST_WAIT_HIGH;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!w_sync[g]) begin
                        w_state_nxt = ST_LOW;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_HIGH;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!w_sync[g]) begin
                        w_state_nxt = ST_WAIT_LOW;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (w_sync[g]) begin
                        w_state_nxt = ST_HIGH;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end
            endcase
            w_db_nxt = db_level(w_state_nxt);
        end

        // Register the level from the next state so x_db moves on the qualifying edge;
        // reset clears everything directly, so no fall pulse is generated.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_db   <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_db   <= w_db_nxt;
                r_rise <= w_db_nxt & ~r_db;
                r_fall <= ~w_db_nxt & r_db;
            end
        end

        assign x_db[g]   = r_db;
        assign x_rise[g] = r_rise;
        assign x_fall[g] = r_fall;
    end

endmodule

// File: tb/tb_multi_input_debouncer.sv
// Directed bench: expected edge events are queued when stimulus is driven and
// matched against x_rise/x_fall pulses as they appear; x_db is spot-checked inline.
module tb_multi_input_debouncer;

    localparam int LAT = 2 + 8 + 1;

    typedef struct packed {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    logic       clk;
    logic       rst;
    logic [3:0] x_raw;
    logic [3:0] x_db;
    logic [3:0] x_rise;
    logic [3:0] x_fall;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    multi_input_debouncer #(
        .N_INPUTS        (4),
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .x_raw  (x_raw),
        .x_db   (x_db),
        .x_rise (x_rise),
        .x_fall (x_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every edge pulse the DUT emits must match the oldest queued expectation.
    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if ((x_rise | x_fall) !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {24'd0, x_rise, x_fall}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_rise", {28'd0, x_rise}, {28'd0, e.rise});
                    chk("ev_fall", {28'd0, x_fall}, {28'd0, e.fall});
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        x_raw = 4'b0000;
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        chk("reset_db", {28'd0, x_db}, 32'd0);
        chk("reset_rise", {28'd0, x_rise}, 32'd0);
        chk("reset_fall", {28'd0, x_fall}, 32'd0);
        rst = 1'b0;
        tick(2);
        chk("idle_db", {28'd0, x_db}, 32'd0);

        // Clean step on channel 0, held 20 cycles, then released
        x_raw[0] = 1'b1;
        exp_q.push_back('{cyc + LAT, 4'b0001, 4'b0000});
        tick(LAT - 1);
        chk("s1_db_early", {28'd0, x_db}, 32'h0);
        tick(1);
        chk("s1_db_rise", {28'd0, x_db}, 32'h1);
        chk("s1_rise_pulse", {28'd0, x_rise}, 32'h1);
        tick(1);
        chk("s1_rise_width", {28'd0, x_rise}, 32'h0);
        tick(8);
        chk("s1_db_hold", {28'd0, x_db}, 32'h1);
        chk("s1_queue", exp_q.size(), 32'd0);
        x_raw[0] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0001});
        tick(LAT - 1);
        chk("s1_db_fall_early", {28'd0, x_db}, 32'h1);
        tick(1);
        chk("s1_db_fall", {28'd0, x_db}, 32'h0);
        chk("s1_fall_pulse", {28'd0, x_fall}, 32'h1);
        chk("s1_no_rise", {28'd0, x_rise}, 32'h0);
        tick(1);
        chk("s1_fall_width", {28'd0, x_fall}, 32'h0);

        // Bounce on channel 1: toggles every 3 cycles for 30 cycles, then holds 1
        for (int k = 0; k < 10; k++) begin
            x_raw[1] = ~x_raw[1];
            for (int j = 0; j < 3; j++) begin
                tick(1);
                chk("s2_bounce_db", {28'd0, x_db}, 32'h0);
            end
        end
        x_raw[1] = 1'b1;
        exp_q.push_back('{cyc + LAT, 4'b0010, 4'b0000});
        tick(LAT - 1);
        chk("s2_db_early", {28'd0, x_db}, 32'h0);
        tick(1);
        chk("s2_db_rise", {28'd0, x_db}, 32'h2);
        tick(3);

        // Glitch on channel 2: high for 7 cycles only
        x_raw[2] = 1'b1;
        tick(7);
        x_raw[2] = 1'b0;
        for (int j = 0; j < 15; j++) begin
            tick(1);
            chk("s3_glitch_db2", {31'd0, x_db[2]}, 32'h0);
        end
        chk("s3_queue", exp_q.size(), 32'd0);

        // Channel 3 rises while channel 1 releases, then channel 3 releases
        x_raw[3] = 1'b1;
        x_raw[1] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b1000, 4'b0010});
        tick(LAT);
        chk("s4_db_set", {28'd0, x_db}, 32'h8);
        tick(5);
        x_raw[3] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b1000});
        tick(LAT - 1);
        chk("s4_db_early", {28'd0, x_db}, 32'h8);
        tick(1);
        chk("s4_db_fall", {28'd0, x_db}, 32'h0);
        chk("s4_fall_pulse", {28'd0, x_fall}, 32'h8);
        chk("s4_no_rise", {28'd0, x_rise}, 32'h0);
        tick(1);
        chk("s4_fall_width", {28'd0, x_fall}, 32'h0);

        // All channels rise together, then fall together
        x_raw = 4'b1111;
        exp_q.push_back('{cyc + LAT, 4'b1111, 4'b0000});
        tick(LAT - 1);
        chk("s5_db_early", {28'd0, x_db}, 32'h0);
        tick(1);
        chk("s5_db_all", {28'd0, x_db}, 32'hf);
        chk("s5_rise_all", {28'd0, x_rise}, 32'hf);
        tick(4);
        x_raw = 4'b0000;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b1111});
        tick(LAT);
        chk("s5_db_none", {28'd0, x_db}, 32'h0);
        chk("s5_fall_all", {28'd0, x_fall}, 32'hf);
        tick(3);
        chk("s5_queue", exp_q.size(), 32'd0);

        // Reset at count 5 of a wait, then again while x_db[0] is high
        x_raw[0] = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("s6_rst1_db", {28'd0, x_db}, 32'h0);
        chk("s6_rst1_rise", {28'd0, x_rise}, 32'h0);
        rst = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0001, 4'b0000});
        tick(LAT - 1);
        chk("s6_requal1_early", {28'd0, x_db}, 32'h0);
        tick(1);
        chk("s6_requal1_db", {28'd0, x_db}, 32'h1);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("s6_rst2_db", {28'd0, x_db}, 32'h0);
        chk("s6_rst2_fall", {28'd0, x_fall}, 32'h0);
        chk("s6_rst2_rise", {28'd0, x_rise}, 32'h0);
        rst = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0001, 4'b0000});
        tick(LAT - 1);
        chk("s6_requal2_early", {28'd0, x_db}, 32'h0);
        tick(1);
        chk("s6_requal2_db", {28'd0, x_db}, 32'h1);
        tick(2);
        x_raw[0] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0001});
        tick(LAT + 3);
        chk("s6_db_final", {28'd0, x_db}, 32'h0);
        chk("final_queue", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
